// File: rtl/coef_collector_if.sv
// Coefficient collector bus: capture stream from the coefficient mapper and
// the read port used by the butterfly datapath.
interface coef_collector_if #(
    parameter int N   = 16,
    parameter int MSB = 16
);
    localparam int AW = $clog2(N / 2);

    logic           load;
    logic [MSB-1:0] data_in;
    logic [1:0]     select_c;
    logic           dv_in;
    logic           rd_en;
    logic [AW-1:0]  rd_addr;
    logic [MSB-1:0] c_out;
    logic [MSB-1:0] cps_out;
    logic [MSB-1:0] cms_out;
    logic           rd_valid;
    logic           ready;
    logic           busy;
    logic           err;

    modport master (
        output load, data_in, select_c, dv_in, rd_en, rd_addr,
        input  c_out, cps_out, cms_out, rd_valid, ready, busy, err
    );

    modport slave (
        input  load, data_in, select_c, dv_in, rd_en, rd_addr,
        output c_out, cps_out, cms_out, rd_valid, ready, busy, err
    );
endinterface

// File: rtl/coef_collector.sv
// Twiddle table collector: gathers C, C+S, C-S words into N/2 entries and serves
// three-word reads. Macro COEF_COLLECTOR_ALIGN_EN delays select_c by one cycle.
module coef_collector #(
    parameter int N   = 16,
    parameter int MSB = 16
) (
    input  logic             clk,
    input  logic             rst,
    coef_collector_if.slave  bus
);
    localparam int             AW   = $clog2(N / 2);
    localparam logic [AW-1:0]  LAST = AW'(N / 2 - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, READY} state_t;

    state_t          state_q;
    logic [AW-1:0]   idx_q;
    logic            ready_q;
    logic            busy_q;
    logic            err_q;
    logic            rd_valid_q;
    logic [MSB-1:0]  c_q;
    logic [MSB-1:0]  cps_q;
    logic [MSB-1:0]  cms_q;

    logic [MSB-1:0]  mem_c_q   [N/2];
    logic [MSB-1:0]  mem_cps_q [N/2];
    logic [MSB-1:0]  mem_cms_q [N/2];

    logic [1:0]      sel_a;
    logic            skip_a;
    logic            wr_en_d;
    logic            last_wr_d;

`ifdef COEF_COLLECTOR_ALIGN_EN
    logic [1:0]      sel_q;
    logic            skip_q;

    // Slot tag arrives one cycle ahead of its ROM word; the first slot after
    // load is stale because sel_q still holds the pre-load value.
    always_ff @(posedge clk) begin
        sel_q <= bus.select_c;
        if (rst) begin
            skip_q <= 1'b0;
        end else if (bus.load) begin
            skip_q <= 1'b1;
        end else if (state_q == CAPTURE) begin
            skip_q <= 1'b0;
        end
    end

    assign sel_a  = sel_q;
    assign skip_a = skip_q;
`else
    assign sel_a  = bus.select_c;
    assign skip_a = 1'b0;
`endif

    assign wr_en_d   = (state_q == CAPTURE) && !rst && !bus.load && !skip_a
                       && (sel_a != 2'd3);
    assign last_wr_d = wr_en_d && (sel_a == 2'd2) && (idx_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (bus.load) begin
            state_q <= CAPTURE;
            idx_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
        end else if (state_q == CAPTURE) begin
            if (last_wr_d) begin
                state_q <= READY;
                busy_q  <= 1'b0;
                ready_q <= 1'b1;
            end else begin
                if (wr_en_d && (sel_a == 2'd2)) begin
                    idx_q <= idx_q + AW'(1);
                end
                // Short stream: publish what we have and flag it.
                if (bus.dv_in) begin
                    state_q <= READY;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    err_q   <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_d) begin
            case (sel_a)
                2'd0:    mem_c_q[idx_q]   <= bus.data_in;
                2'd1:    mem_cps_q[idx_q] <= bus.data_in;
                2'd2:    mem_cms_q[idx_q] <= bus.data_in;
                default: ;
            endcase
        end
    end

    // Read port: one-cycle latency, data held when no valid read occurs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            c_q        <= '0;
            cps_q      <= '0;
            cms_q      <= '0;
        end else if (bus.rd_en && ready_q) begin
            rd_valid_q <= 1'b1;
            c_q        <= mem_c_q[bus.rd_addr];
            cps_q      <= mem_cps_q[bus.rd_addr];
            cms_q      <= mem_cms_q[bus.rd_addr];
        end else begin
            rd_valid_q <= 1'b0;
        end
    end

    assign bus.c_out    = c_q;
    assign bus.cps_out  = cps_q;
    assign bus.cms_out  = cms_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.ready    = ready_q;
    assign bus.busy     = busy_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_coef_collector.sv
// Bench for coef_collector: directed streams plus randomized captures checked
// against a list-level table model.
module tb_coef_collector;
    localparam int N   = 16;
    localparam int MSB = 16;
    localparam int NE  = N / 2;

    typedef struct packed {
        logic [1:0]     sel;
        logic [MSB-1:0] data;
    } word_t;

    logic clk;
    logic rst;

    coef_collector_if #(.N(N), .MSB(MSB)) bus ();

    coef_collector #(.N(N), .MSB(MSB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    logic [MSB-1:0] mt [NE][3];
    logic [MSB-1:0] prev_data;
    logic [MSB-1:0] hold_c, hold_cps, hold_cms;
    word_t          q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Applies the first n words of a stream to the table; returns entries completed.
    function automatic int model_apply(input word_t ws[$], input int n);
        int idx = 0;
        for (int i = 0; i < n && idx < NE; i++) begin
            if (ws[i].sel != 2'd3) begin
                mt[idx][ws[i].sel] = ws[i].data;
                if (ws[i].sel == 2'd2) idx++;
            end
        end
        return idx;
    endfunction

    task automatic drive_word(input word_t w);
        bus.select_c = w.sel;
`ifdef COEF_COLLECTOR_ALIGN_EN
        bus.data_in = prev_data;
        prev_data   = w.data;
`else
        bus.data_in = w.data;
`endif
        tick();
    endtask

    task automatic flush();
`ifdef COEF_COLLECTOR_ALIGN_EN
        bus.select_c = 2'd3;
        bus.data_in  = prev_data;
        tick();
`endif
        bus.select_c = 2'd3;
    endtask

    task automatic drive_stream(input int n);
        for (int i = 0; i < n; i++) drive_word(q[i]);
        flush();
    endtask

    task automatic do_load();
        bus.select_c = 2'd3;
        bus.load     = 1'b1;
        tick();
        bus.load     = 1'b0;
    endtask

    task automatic do_dv();
        bus.select_c = 2'd3;
        bus.dv_in    = 1'b1;
        tick();
        bus.dv_in    = 1'b0;
    endtask

    task automatic read_check(input int addr);
        bus.rd_en   = 1'b1;
        bus.rd_addr = addr[2:0];
        tick();
        bus.rd_en   = 1'b0;
        check($sformatf("rd_valid[%0d]", addr), bus.rd_valid, 1);
        check($sformatf("c_out[%0d]", addr),   bus.c_out,   mt[addr][0]);
        check($sformatf("cps_out[%0d]", addr), bus.cps_out, mt[addr][1]);
        check($sformatf("cms_out[%0d]", addr), bus.cms_out, mt[addr][2]);
        hold_c   = mt[addr][0];
        hold_cps = mt[addr][1];
        hold_cms = mt[addr][2];
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < NE; a++) read_check(a);
        tick();
        check({tag, " rd_valid drop"}, bus.rd_valid, 0);
    endtask

    task automatic build_seq(input logic [MSB-1:0] base);
        q.delete();
        for (int k = 0; k < 3 * NE; k++) q.push_back('{sel: 2'(k % 3), data: base + MSB'(k)});
    endtask

    task automatic check_status(input string tag, input logic r, input logic b, input logic e);
        check({tag, " ready"}, bus.ready, r);
        check({tag, " busy"},  bus.busy,  b);
        check({tag, " err"},   bus.err,   e);
    endtask

    initial begin
        int done;
        int n;
        n_cmp = 0;
        n_bad = 0;
        prev_data    = '0;
        bus.load     = 1'b0;
        bus.data_in  = '0;
        bus.select_c = 2'd3;
        bus.dv_in    = 1'b0;
        bus.rd_en    = 1'b0;
        bus.rd_addr  = '0;
        rst = 1'b1;
        tick();
        tick();
        check_status("reset", 0, 0, 0);
        check("reset rd_valid", bus.rd_valid, 0);
        check("reset c_out", bus.c_out, 0);
        check("reset cps_out", bus.cps_out, 0);
        check("reset cms_out", bus.cms_out, 0);
        rst = 1'b0;
        tick();

        // Full capture of 0x0100+k
        build_seq(16'h0100);
        do_load();
        check_status("load", 0, 1, 0);
        drive_stream(q.size());
        check_status("full", 1, 0, 0);
        done = model_apply(q, q.size());
        check("full entries", done, NE);
        read_check(7);
        check("entry7 c", bus.c_out, 16'h0115);
        check("entry7 cps", bus.cps_out, 16'h0116);
        check("entry7 cms", bus.cms_out, 16'h0117);
        read_all("full");

        // Invalid slot mid-stream must not write or advance
        build_seq(16'h0100);
        q.insert(10, '{sel: 2'd3, data: 16'hDEAD});
        do_load();
        drive_stream(q.size());
        check_status("invalid", 1, 0, 0);
        read_check(3);
        check("inv entry3 cps", bus.cps_out, 16'h010A);
        read_all("invalid");

        // Short stream: dv after 9 words
        build_seq(16'h0300);
        do_load();
        drive_stream(9);
        do_dv();
        check_status("short", 1, 0, 1);
        void'(model_apply(q, 9));
        read_check(3);
        check("short entry3 cps old", bus.cps_out, 16'h010A);
        check("short entry3 cms old", bus.cms_out, 16'h010B);
        read_check(2);
        check("short entry2 c new", bus.c_out, 16'h0306);
        read_all("short");

        // Reset during capture, with a read attempted while not ready
        build_seq(16'h0500);
        do_load();
        drive_stream(10);
        void'(model_apply(q, 10));
        bus.rd_en = 1'b1;
        bus.rd_addr = 3'd1;
        tick();
        bus.rd_en = 1'b0;
        check("notready rd_valid", bus.rd_valid, 0);
        check("notready c hold", bus.c_out, hold_c);
        check("notready cms hold", bus.cms_out, hold_cms);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_status("rst cap", 0, 0, 0);
        check("rst cap rd_valid", bus.rd_valid, 0);
        check("rst cap c_out", bus.c_out, 0);
        check("rst cap cps_out", bus.cps_out, 0);
        check("rst cap cms_out", bus.cms_out, 0);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        check("idle rd_valid", bus.rd_valid, 0);

        // Restart by load mid-stream
        build_seq(16'h0400);
        do_load();
        drive_stream(12);
        check_status("pre-restart", 0, 1, 0);
        build_seq(16'h0200);
        do_load();
        drive_stream(q.size());
        check_status("restart", 1, 0, 0);
        void'(model_apply(q, q.size()));
        read_check(0);
        check("restart entry0 c", bus.c_out, 16'h0200);
        check("restart entry0 cps", bus.cps_out, 16'h0201);
        check("restart entry0 cms", bus.cms_out, 16'h0202);
        read_all("restart");

        // Randomized captures, some cut short by dv_in
        for (int it = 0; it < 8; it++) begin
            q.delete();
            for (int k = 0; k < 3 * NE; k++) begin
                if ($urandom_range(0, 4) == 0)
                    q.push_back('{sel: 2'd3, data: MSB'($urandom)});
                q.push_back('{sel: 2'(k % 3), data: MSB'($urandom)});
            end
            n = (it % 2 == 1) ? int'($urandom_range(0, q.size() - 1)) : q.size();
            do_load();
            drive_stream(n);
            done = model_apply(q, n);
            if (done < NE) do_dv();
            check_status($sformatf("rand%0d", it), 1, 0, (done < NE) ? 1'b1 : 1'b0);
            read_all($sformatf("rand%0d", it));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/coef_collector.md
COEF_COLLECTOR -- requirements
Module: coef_collector

Interface
REQ-001 SHALL have parameter N, default 16, meaning FFT length; the block holds N/2 twiddle entries.
REQ-002 SHALL have parameter MSB, default 16, meaning coefficient word width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port load  input  1  one-cycle pulse; arms capture of a new coefficient stream.
REQ-006 SHALL have port data_in  input  MSB  coefficient word from the coefficient mapper.
REQ-007 SHALL have port select_c  input  2  word slot of data_in: 0=C, 1=C+S, 2=C-S; 3 is invalid.
REQ-008 SHALL have port dv_in  input  1  end-of-stream strobe from the mapper.
REQ-009 SHALL have port rd_en  input  1  read request from the butterfly datapath.
REQ-010 SHALL have port rd_addr  input  $clog2(N/2)  entry index to read.
REQ-011 SHALL have port c_out  output  MSB  slot-0 word of the read entry.
REQ-012 SHALL have port cps_out  output  MSB  slot-1 word of the read entry.
REQ-013 SHALL have port cms_out  output  MSB  slot-2 word of the read entry.
REQ-014 SHALL have port rd_valid  output  1  c_out/cps_out/cms_out are valid.
REQ-015 SHALL have port ready  output  1  the table is complete and readable.
REQ-016 SHALL have port busy  output  1  capture is in progress.
REQ-017 SHALL have port err  output  1  sticky flag for a short stream; cleared by load or rst.

Function
REQ-018 SHALL implement a state machine with states IDLE, CAPTURE and READY.
REQ-019 SHALL transition from IDLE or READY to CAPTURE on load; entry index=0, ready=0, busy=1, err=0.
REQ-020 SHALL, in CAPTURE, on each cycle with aligned select_c in 0..2, write aligned data_in into slot select_c of the entry at the current entry index.
REQ-021 SHALL ignore aligned select_c=3: no write and no index advance.
REQ-022 SHALL increment the entry index after each write to slot 2.
REQ-023 SHALL, on the slot-2 write to entry N/2-1, go to READY the next cycle: busy=0, ready=1.
REQ-024 SHALL, if dv_in is seen in CAPTURE before entry N/2-1 is complete, set err=1, go to READY, and retain any entries not written.
REQ-025 SHALL ignore dv_in in IDLE and READY.
REQ-026 SHALL, on load during CAPTURE, restart capture at entry 0; load has priority over the completion condition in the same cycle.
REQ-027 SHALL, on rd_en with ready=1, present all three words of rd_addr on c_out/cps_out/cms_out with rd_valid=1 exactly 1 cycle later.
REQ-028 SHALL, on rd_en with ready=0, drive rd_valid=0 next cycle and hold the data outputs unchanged.
REQ-029 SHALL drive rd_valid=0 in any cycle following a cycle without rd_en.
REQ-030 SHALL make a write in the same cycle as a read of the same entry return the old contents.
REQ-031 SHALL use storage of 3*(N/2) words of MSB bits; the table contents SHALL be undefined until the first complete capture.

Reset
REQ-032 SHALL, on rst=1 at a clock edge, enter IDLE with ready=0, busy=0, err=0, rd_valid=0, c_out=cps_out=cms_out=0, and entry index=0.
REQ-033 SHALL, on rst during CAPTURE, abort capture without clearing table contents.
REQ-034 SHALL give rst priority over load, dv_in and rd_en.

Configuration
REQ-035 SHALL provide macro COEF_COLLECTOR_ALIGN_EN; when defined, select_c SHALL be registered one cycle before use, matching the one-cycle read latency of the coefficient ROM.
REQ-036 SHALL, without COEF_COLLECTOR_ALIGN_EN, use select_c in the same cycle as data_in, with no delay.
REQ-037 SHALL, with COEF_COLLECTOR_ALIGN_EN, ignore the first aligned slot after load, because the register still holds the value from before load.

Verification
REQ-038 SHALL test a full capture (N=16, ALIGN off): load, then 24 words with select_c=0,1,2 repeating and data=0x0100+k -> ready=1 one cycle after word 23; read entry 7 gives c_out=0x0115, cps_out=0x0116, cms_out=0x0117, with rd_valid 1 cycle after rd_en.
REQ-039 SHALL test a short stream: dv_in after 9 words -> err=1, ready=1, entries 0..2 are new and entry 3 slots 1/2 keep their old values.
REQ-040 SHALL test an invalid slot: select_c=3 inserted mid-stream with data=0xDEAD -> no write, index unchanged, and the final table equals REQ-038's.
REQ-041 SHALL test reset during capture: rst at word 10 -> next cycle busy=0, ready=0, err=0, rd_valid=0, outputs 0; a subsequent rd_en gives rd_valid=0.
REQ-042 SHALL test restart by load: load at word 12, then a full 24-word stream of 0x0200+k -> entry 0 reads 0x0200/0x0201/0x0202.
REQ-043 SHALL test ALIGN on: the same stream as REQ-038 with data delayed by 1 cycle relative to select_c -> the same readback as REQ-038.
